// File: rtl/uart_inst_loader.sv
// UART (8N1) program loader: assembles little-endian words into instruction memory while holding the CPU in reset.
// Optional feature: define UART_INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module uart_inst_loader #(
  parameter int unsigned CLKS_PER_BIT = 52,
  parameter int unsigned INST_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] inst_wr_addr,
  output logic [31:0] inst_wr_data,
  output logic        inst_wr_en,
  output logic        cpu_hold,
  output logic        loaded,
  output logic        frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    WORD,
`ifdef UART_INST_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } ld_state_t;

  // rx front end
  logic             rx_s1, rx_s2, rx_d;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             byte_valid, byte_valid_nxt;
  logic             frame_err_nxt;

  // loader
  ld_state_t        state, state_nxt;
  logic [15:0]      n, n_nxt;
  logic [15:0]      k, k_nxt;
  logic [1:0]       b, b_nxt;
  logic [31:0]      word, word_nxt;
  logic [31:0]      addr_nxt, data_nxt;
  logic             wr_en_nxt, loaded_nxt, cpu_hold_nxt;
`ifdef UART_INST_LOADER_CHECKSUM_EN
  logic [7:0]       csum, csum_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_d         <= 1'b1;
      rx_state     <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid   <= 1'b0;
      frame_err    <= 1'b0;
      state        <= CNT_LO;
      n            <= '0;
      k            <= '0;
      b            <= '0;
      word         <= '0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      inst_wr_en   <= 1'b0;
      loaded       <= 1'b0;
      cpu_hold     <= 1'b1;
`ifdef UART_INST_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      rx_s1        <= rx;
      rx_s2        <= rx_s1;
      rx_d         <= rx_s2;
      rx_state     <= rx_state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      shreg        <= shreg_nxt;
      byte_valid   <= byte_valid_nxt;
      frame_err    <= frame_err_nxt;
      state        <= state_nxt;
      n            <= n_nxt;
      k            <= k_nxt;
      b            <= b_nxt;
      word         <= word_nxt;
      inst_wr_addr <= addr_nxt;
      inst_wr_data <= data_nxt;
      inst_wr_en   <= wr_en_nxt;
      loaded       <= loaded_nxt;
      cpu_hold     <= cpu_hold_nxt;
`ifdef UART_INST_LOADER_CHECKSUM_EN
      csum         <= csum_nxt;
`endif
    end
  end

  // Receiver: mid-bit sampling timed from the synchronized start edge
  always_comb begin
    rx_state_nxt   = rx_state;
    cnt_nxt        = cnt + CNT_W'(1);
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = frame_err;
    case (rx_state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_d && !rx_s2) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt      = '0;
          bit_idx_nxt  = '0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_s2, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt      = '0;
          rx_state_nxt = RX_IDLE;
          if (rx_s2) byte_valid_nxt = 1'b1;
          else       frame_err_nxt  = 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Loader: count bytes, then little-endian words; N=0 and a good checksum release the CPU immediately
  always_comb begin
    state_nxt  = state;
    n_nxt      = n;
    k_nxt      = k;
    b_nxt      = b;
    word_nxt   = word;
    addr_nxt   = inst_wr_addr;
    data_nxt   = inst_wr_data;
    wr_en_nxt  = 1'b0;
    loaded_nxt = (state == DONE);
`ifdef UART_INST_LOADER_CHECKSUM_EN
    csum_nxt   = csum;
`endif
    if (byte_valid) begin
      case (state)
        CNT_LO: begin
          n_nxt[7:0] = shreg;
          state_nxt  = CNT_HI;
        end
        CNT_HI: begin
          n_nxt[15:8] = shreg;
          k_nxt       = '0;
          b_nxt       = '0;
`ifdef UART_INST_LOADER_CHECKSUM_EN
          csum_nxt    = '0;
`endif
          if ({shreg, n[7:0]} == 16'd0) begin
            state_nxt  = DONE;
            loaded_nxt = 1'b1;
          end else begin
            state_nxt  = WORD;
          end
        end
        WORD: begin
          word_nxt[{b, 3'b000} +: 8] = shreg;
          b_nxt = b + 2'd1;
`ifdef UART_INST_LOADER_CHECKSUM_EN
          csum_nxt = csum ^ shreg;
`endif
          if (b == 2'd3) begin
            data_nxt  = {shreg, word[23:0]};
            addr_nxt  = {14'b0, k, 2'b00};
            wr_en_nxt = (32'(k) < INST_WORDS);
            k_nxt     = k + 16'd1;
            if (k + 16'd1 == n) begin
`ifdef UART_INST_LOADER_CHECKSUM_EN
              state_nxt = CHECK;
`else
              state_nxt = DONE;
`endif
            end
          end
        end
`ifdef UART_INST_LOADER_CHECKSUM_EN
        CHECK: begin
          if (shreg == csum) begin
            state_nxt  = DONE;
            loaded_nxt = 1'b1;
          end else begin
            state_nxt  = CNT_LO;
          end
        end
`endif
        DONE:    ;
        default: state_nxt = CNT_LO;
      endcase
    end
    cpu_hold_nxt = ~loaded_nxt;
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Randomized bench for uart_inst_loader: a full-depth and a depth-1 instance share one rx line,
// and a byte-stream model predicts writes, loaded/cpu_hold and frame_err.
module tb_uart_inst_loader;
  localparam int unsigned CPB = 4;

  typedef logic [7:0] bq_t[$];
  typedef bit         gq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] a_addr, a_data, s_addr, s_data;
  logic        a_en, a_hold, a_loaded, a_ferr;
  logic        s_en, s_hold, s_loaded, s_ferr;

  int          total = 0;
  int          bad   = 0;
  longint      cyc   = 0;

  logic [63:0] wr_a[$];
  logic [63:0] wr_s[$];
  longint      last_wr_a = -1;
  longint      load_cyc_a = -1;

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .INST_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .inst_wr_addr(a_addr), .inst_wr_data(a_data), .inst_wr_en(a_en),
    .cpu_hold(a_hold), .loaded(a_loaded), .frame_err(a_ferr));

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .INST_WORDS(1)) dut_small (
    .clk(clk), .reset(reset), .rx(rx),
    .inst_wr_addr(s_addr), .inst_wr_data(s_data), .inst_wr_en(s_en),
    .cpu_hold(s_hold), .loaded(s_loaded), .frame_err(s_ferr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/loaded monitor, cleared while reset is held
  always @(negedge clk) begin
    if (reset) begin
      wr_a.delete();
      wr_s.delete();
      last_wr_a  = -1;
      load_cyc_a = -1;
    end else begin
      if (a_en) begin
        wr_a.push_back({a_addr, a_data});
        last_wr_a = cyc;
      end
      if (s_en) wr_s.push_back({s_addr, s_data});
      if (a_loaded && load_cyc_a < 0) load_cyc_a = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit good);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!good) repeat (CPB) @(negedge clk);
  endtask

  function automatic logic [7:0] xor_payload(input bq_t q);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < q.size(); i++) x ^= q[i];
    return x;
  endfunction

  // Checksum byte appended only when the feature is built in; flip=1 corrupts it
  function automatic bq_t with_csum(input bq_t q, input bit flip);
    bq_t r = q;
`ifdef UART_INST_LOADER_CHECKSUM_EN
    if (q.size() >= 2 && {q[1], q[0]} != 16'd0) r.push_back(xor_payload(q) ^ {7'd0, flip});
`else
    if (flip) r = q;
`endif
    return r;
  endfunction

  task automatic run_case(input string name, input bq_t bytes, input gq_t good, input bit rnd_gaps);
    bq_t         s;
    logic [63:0] exp_a[$];
    logic [63:0] exp_s[$];
    bit          exp_loaded = 0;
    bit          exp_ferr   = 0;
    bit          stop       = 0;
    int          pos        = 0;
    int          n          = 0;
    int          last_n     = -1;
    logic [7:0]  x;
    logic [31:0] w;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], good[i]);
      if (rnd_gaps) begin
        if ($urandom_range(0, 5) == 0) begin
          rx = 1'b0;
          @(negedge clk);
          idle(CPB + 2);
        end
        idle($urandom_range(0, 2));
      end
    end
    idle(4 * CPB);

    // Model: good bytes form count/word segments; bytes after DONE are ignored
    for (int i = 0; i < bytes.size(); i++) begin
      if (good[i]) s.push_back(bytes[i]);
      else exp_ferr = 1;
    end
    while (!exp_loaded && !stop && s.size() - pos >= 2) begin
      n = int'({s[pos+1], s[pos]});
      pos += 2;
      x = 8'h00;
      for (int kk = 0; kk < n; kk++) begin
        if (pos + 4 > s.size()) begin
          stop = 1;
          break;
        end
        w = {s[pos+3], s[pos+2], s[pos+1], s[pos]};
        x ^= s[pos] ^ s[pos+1] ^ s[pos+2] ^ s[pos+3];
        exp_a.push_back({32'(4 * kk), w});
        if (kk < 1) exp_s.push_back({32'(4 * kk), w});
        pos += 4;
      end
      if (stop) break;
`ifdef UART_INST_LOADER_CHECKSUM_EN
      if (n == 0) exp_loaded = 1;
      else if (pos >= s.size()) stop = 1;
      else begin
        if (s[pos] == x) exp_loaded = 1;
        pos++;
      end
`else
      exp_loaded = 1;
`endif
      last_n = n;
    end

    check({name, "_nwr"}, 64'(wr_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++)
      check($sformatf("%s_wr%0d", name, i), wr_a[i], exp_a[i]);
    check({name, "_nwr_small"}, 64'(wr_s.size()), 64'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < wr_s.size(); i++)
      check($sformatf("%s_wrs%0d", name, i), wr_s[i], exp_s[i]);
    check({name, "_loaded"}, 64'({a_loaded, s_loaded}), 64'({exp_loaded, exp_loaded}));
    check({name, "_hold"}, 64'({a_hold, s_hold}), 64'({!exp_loaded, !exp_loaded}));
    check({name, "_ferr"}, 64'({a_ferr, s_ferr}), 64'({exp_ferr, exp_ferr}));
`ifndef UART_INST_LOADER_CHECKSUM_EN
    if (exp_loaded && last_n > 0)
      check({name, "_hold_lat"}, 64'(load_cyc_a - last_wr_a), 64'd1);
`endif
  endtask

  initial begin
    bq_t q;
    gq_t g;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", {a_addr, a_data}, 64'd0);
    check("rst_s", {s_addr, s_data}, 64'd0);
    check("rst_ctl", 64'({a_en, a_hold, a_loaded, a_ferr, s_en, s_hold, s_loaded, s_ferr}),
          64'(8'b0100_0100));
    reset = 1'b0;

    // two words, back-to-back; depth-1 instance writes only addr 0
    q = with_csum('{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00}, 0);
    g = {};
    foreach (q[i]) g.push_back(1'b1);
    run_case("two_words", q, g, 0);
    if (wr_a.size() >= 2) begin
      check("tp_w0", wr_a[0], {32'd0, 32'h00100513});
      check("tp_w1", wr_a[1], {32'd4, 32'h00100073});
    end

    q = '{8'h00, 8'h00};
    g = '{1'b1, 1'b1};
    run_case("n_zero", q, g, 0);

    // stop bit low mid-word: byte dropped, next byte takes its slot
    q = with_csum('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'h55, 8'hCC, 8'hDD}, 0);
    g = {};
    foreach (q[i]) g.push_back(i != 4);
    run_case("frame_err", q, g, 0);

    // reset after three payload bytes, then a fresh one-word program
    reset = 1'b0;
    foreach (q[i]) if (i < 5) send_byte(8'(i + 1), 1'b1);
    q = with_csum('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0);
    g = {};
    foreach (q[i]) g.push_back(1'b1);
    run_case("mid_reset", q, g, 0);
    if (wr_a.size() >= 1) check("mid_reset_w", wr_a[0], {32'd0, 32'hDDCCBBAA});

`ifdef UART_INST_LOADER_CHECKSUM_EN
    // bad checksum returns to CNT_LO; a following 00 00 then completes
    q = with_csum('{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00}, 1);
    g = {};
    foreach (q[i]) g.push_back(1'b1);
    run_case("csum_bad", q, g, 0);
    q.push_back(8'h00);
    q.push_back(8'h00);
    g.push_back(1'b1);
    g.push_back(1'b1);
    run_case("csum_retry", q, g, 0);
`endif

    for (int t = 0; t < 10; t++) begin
      int nn;
      int badpos;
      nn = $urandom_range(0, 3);
      q = {8'(nn), 8'h00};
      for (int i = 0; i < 4 * nn; i++) q.push_back(8'($urandom_range(0, 255)));
      q = with_csum(q, ($urandom_range(0, 3) == 0));
      g = {};
      foreach (q[i]) g.push_back(1'b1);
      badpos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, q.size())) : -1;
      if (badpos >= 0) begin
        q.insert(badpos, 8'($urandom_range(0, 255)));
        g.insert(badpos, 1'b0);
      end
      run_case($sformatf("rnd%0d", t), q, g, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
